// File: rtl/iic_page_writer.sv
`default_nettype none
// iic_page_writer (rev 1.0): single-master I2C page-write engine that drains a FWFT byte FIFO
// into a 24Cxx EEPROM as START, {DEV_ADDR,W}, word address high/low, N data bytes, STOP.
module iic_page_writer #(
    parameter int         SYS_CLK_FREQ = 50_000_000,
    parameter int         SCL_FREQ     = 250_000,
    parameter int         PAGE_SIZE    = 32,
    parameter logic [6:0] DEV_ADDR     = 7'b1010000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [15:0] word_addr,
    input  logic [5:0]  byte_cnt,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        scl,
    output logic        sda_oe,
    input  logic        sda_in,
    output logic        busy,
    output logic        done,
    output logic        ack_err
);

    localparam int            QCNT     = SYS_CLK_FREQ / (SCL_FREQ * 4);
    localparam int            QW       = (QCNT > 1) ? $clog2(QCNT) : 1;
    localparam logic [QW-1:0] QLAST    = QW'(QCNT - 1);
    localparam logic [6:0]    PAGE_MAX = 7'(PAGE_SIZE);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_START  = 4'd1,
        S_DEV    = 4'd2,
        S_ADDR_H = 4'd3,
        S_ADDR_L = 4'd4,
        S_DATA   = 4'd5,
        S_ACK    = 4'd6,
        S_STOP   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t          state_q, state_d;
    state_t          ack_from_q, ack_from_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      quarter_q, quarter_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [5:0]      left_q, left_d;
    logic [15:0]     addr_q, addr_d;
    logic            nack_q, nack_d;
    logic            pending_q, pending_d;
    logic            ack_err_q, ack_err_d;

    logic            q_tick;
    logic            slot_end;
    logic            bit_scl;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            ack_from_q <= S_IDLE;
            qcnt_q     <= '0;
            quarter_q  <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            left_q     <= '0;
            addr_q     <= '0;
            nack_q     <= 1'b0;
            pending_q  <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_from_q <= ack_from_d;
            qcnt_q     <= qcnt_d;
            quarter_q  <= quarter_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            left_q     <= left_d;
            addr_q     <= addr_d;
            nack_q     <= nack_d;
            pending_q  <= pending_d;
            ack_err_q  <= ack_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_from_d = ack_from_q;
        qcnt_d     = qcnt_q;
        quarter_d  = quarter_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        left_d     = left_q;
        addr_d     = addr_q;
        nack_d     = nack_q;
        pending_d  = pending_q;
        ack_err_d  = ack_err_q;

        fifo_rd_en = 1'b0;
        scl        = 1'b1;
        sda_oe     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        q_tick   = (qcnt_q == QLAST);
        slot_end = q_tick && (quarter_q == 2'd3);
        bit_scl  = (quarter_q == 2'd1) || (quarter_q == 2'd2);

        // Quarter timing runs in every bus state except while stalled on an empty FIFO.
        if (state_q != S_IDLE && state_q != S_DONE && !pending_q) begin
            if (q_tick) begin
                qcnt_d    = '0;
                quarter_d = quarter_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && (byte_cnt != 6'd0) && ({1'b0, byte_cnt} <= PAGE_MAX)) begin
                    state_d   = S_START;
                    addr_d    = word_addr;
                    left_d    = byte_cnt;
                    ack_err_d = 1'b0;
                    qcnt_d    = '0;
                    quarter_d = '0;
                end
            end

            S_START: begin
                busy   = 1'b1;
                sda_oe = quarter_q[1];
                if (slot_end) begin
                    state_d = S_DEV;
                    shift_d = {DEV_ADDR, 1'b0};
                    bit_d   = '0;
                end
            end

            S_DEV, S_ADDR_H, S_ADDR_L, S_DATA: begin
                busy = 1'b1;
                if (pending_q) begin
                    scl    = 1'b0;
                    sda_oe = 1'b0;
                    if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        shift_d    = fifo_dout;
                        left_d     = left_q - 6'd1;
                        pending_d  = 1'b0;
                    end
                end else begin
                    scl    = bit_scl;
                    sda_oe = ~shift_q[7];
                    if (slot_end) begin
                        if (bit_q == 3'd7) begin
                            state_d    = S_ACK;
                            ack_from_d = state_q;
                            bit_d      = '0;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            bit_d   = bit_q + 3'd1;
                        end
                    end
                end
            end

            S_ACK: begin
                busy   = 1'b1;
                scl    = bit_scl;
                sda_oe = 1'b0;
                if ((quarter_q == 2'd2) && (qcnt_q == '0)) begin
                    nack_d = sda_in;
                    if (sda_in) begin
                        ack_err_d = 1'b1;
                    end
                end
                if (slot_end) begin
                    if (nack_q) begin
                        state_d = S_STOP;
                    end else begin
                        case (ack_from_q)
                            S_DEV: begin
                                state_d = S_ADDR_H;
                                shift_d = addr_q[15:8];
                            end
                            S_ADDR_H: begin
                                state_d = S_ADDR_L;
                                shift_d = addr_q[7:0];
                            end
                            default: begin
                                if (left_q == 6'd0) begin
                                    state_d = S_STOP;
                                end else begin
                                    state_d = S_DATA;
                                    if (fifo_empty) begin
                                        pending_d = 1'b1;
                                    end else begin
                                        fifo_rd_en = 1'b1;
                                        shift_d    = fifo_dout;
                                        left_d     = left_q - 6'd1;
                                    end
                                end
                            end
                        endcase
                    end
                end
            end

            S_STOP: begin
                busy   = 1'b1;
                scl    = (quarter_q != 2'd0);
                sda_oe = (quarter_q != 2'd3);
                if (slot_end) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ack_err = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_iic_page_writer.sv
`default_nettype none
// tb_iic_page_writer: directed transaction vectors plus hand sequences for stalls, reset and
// ignored starts; a bus-level slave model decodes SDA and drives ACK/NACK.
module tb_iic_page_writer;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] word_addr = 16'h0000;
    logic [5:0]  byte_cnt = 6'd0;
    logic [7:0]  fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        scl;
    logic        sda_oe;
    logic        sda_in;
    logic        busy;
    logic        done;
    logic        ack_err;

    always #5 sys_clk = ~sys_clk;

    iic_page_writer #(
        .SYS_CLK_FREQ(50_000_000),
        .SCL_FREQ    (3_125_000),
        .PAGE_SIZE   (32),
        .DEV_ADDR    (7'b1010000)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .word_addr (word_addr),
        .byte_cnt  (byte_cnt),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .scl       (scl),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err)
    );

    // FWFT FIFO: the initial block owns the write side, the clocked block owns the read side.
    logic [7:0] fmem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       flush = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = fmem[rd_ptr[5:0]];

    always @(posedge sys_clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1;
    end

    // Slave model: decodes frames on the wire and pulls SDA for ACK unless told to NACK.
    logic       slave_pull = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       in_frame = 1'b0;
    logic       mon_clr = 1'b0;
    logic       sda_line;
    logic [7:0] sh = 8'h00;
    logic [7:0] rx [0:63];
    int         nack_byte = -1;
    int         bitcnt = 0;
    int         rx_n = 0;
    int         stop_cnt = 0;

    assign sda_line = ~(sda_oe | slave_pull);
    assign sda_in   = sda_line;

    always @(negedge sys_clk) begin
        if (mon_clr || !sys_rst_n) begin
            in_frame   <= 1'b0;
            slave_pull <= 1'b0;
            bitcnt     <= 0;
            if (mon_clr) begin
                rx_n     <= 0;
                stop_cnt <= 0;
            end
        end else if (scl && prev_scl && prev_sda && !sda_line) begin
            in_frame <= 1'b1;
            bitcnt   <= 0;
        end else if (scl && prev_scl && !prev_sda && sda_line) begin
            stop_cnt <= stop_cnt + 1;
            in_frame <= 1'b0;
        end else if (in_frame && scl && !prev_scl) begin
            if (bitcnt < 8) begin
                sh     <= {sh[6:0], sda_line};
                bitcnt <= bitcnt + 1;
            end else begin
                if (rx_n < 64) rx[rx_n] <= sh;
                rx_n   <= rx_n + 1;
                bitcnt <= 0;
            end
        end else if (in_frame && !scl && prev_scl) begin
            slave_pull <= (bitcnt == 8) && (rx_n != nack_byte);
        end
        prev_scl <= scl;
        prev_sda <= sda_line;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        int          n;
        logic [7:0]  base;
        logic [7:0]  step;
        int          nfifo;
        int          nack;
        int          exp_done_k;
        int          exp_pops;
        int          exp_err;
        int          exp_rx;
    } vec_t;

    vec_t vt [5];
    int   pop_at [0:63];
    int   push_k = -1;
    int   hold_lo = 0;
    int   hold_hi = -1;
    int   extra_start_k = -1;

    // Runs one transaction; k counts negedges after the cycle in which start was raised.
    task automatic run(input vec_t v, input string tag);
        int         done_k;
        int         np;
        int         busy_lo;
        int         hold_bad;
        int         gap_bad;
        int         rx_bad;
        int         extra;
        logic [7:0] e;
        flush     = 1'b1;
        mon_clr   = 1'b1;
        nack_byte = v.nack;
        @(negedge sys_clk);
        #1;
        flush   = 1'b0;
        mon_clr = 1'b0;
        for (int i = 0; i < v.nfifo; i++) begin
            fmem[wr_ptr[5:0]] = v.base + 8'(i) * v.step;
            wr_ptr++;
        end
        extra     = (push_k > 0) ? 1 : 0;
        word_addr = v.addr;
        byte_cnt  = 6'(v.n);
        start     = 1'b1;
        done_k    = 0;
        np        = 0;
        busy_lo   = 0;
        hold_bad  = 0;
        for (int k = 1; k <= 20000 && done_k == 0; k++) begin
            @(negedge sys_clk);
            start = (k == extra_start_k);
            if (k == 1) word_addr = ~v.addr;
            if (k == push_k) begin
                fmem[wr_ptr[5:0]] = v.base + 8'(v.nfifo) * v.step;
                wr_ptr++;
            end
            #1;
            if (fifo_rd_en) begin
                if (np < 64) pop_at[np] = k;
                np++;
            end
            if (done) done_k = k;
            else if (!busy) busy_lo++;
            if (k >= hold_lo && k <= hold_hi && (scl || sda_oe)) hold_bad++;
        end
        start = 1'b0;
        chk({tag, " done latency"}, done_k, v.exp_done_k);
        chk({tag, " busy during txn"}, busy_lo, 0);
        chk({tag, " busy at done"}, int'(busy), 0);
        chk({tag, " ack_err"}, int'(ack_err), v.exp_err);
        chk({tag, " pop count"}, np, v.exp_pops);
        if (v.exp_pops > 0) chk({tag, " first pop cycle"}, pop_at[0], 448);
        if (push_k < 0 && np > 1) begin
            gap_bad = 0;
            for (int i = 1; i < np && i < 64; i++)
                if (pop_at[i] - pop_at[i-1] != 144) gap_bad++;
            chk({tag, " pop spacing errors"}, gap_bad, 0);
        end
        chk({tag, " bytes on bus"}, rx_n, v.exp_rx);
        rx_bad = 0;
        for (int j = 0; j < rx_n && j < 64; j++) begin
            e = (j == 0) ? 8'hA0 : (j == 1) ? v.addr[15:8] : (j == 2) ? v.addr[7:0]
                : v.base + 8'(j - 3) * v.step;
            if (rx[j] !== e) rx_bad++;
        end
        chk({tag, " byte value errors"}, rx_bad, 0);
        chk({tag, " stop count"}, stop_cnt, 1);
        chk({tag, " fifo residue"}, wr_ptr - rd_ptr, v.nfifo + extra - v.exp_pops);
        if (hold_hi >= hold_lo) chk({tag, " scl/sda held during stall"}, hold_bad, 0);
    endtask

    task automatic bad_start(input int bc, input string tag);
        int act;
        act = 0;
        @(negedge sys_clk);
        word_addr = 16'h1111;
        byte_cnt  = 6'(bc);
        start     = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge sys_clk);
            start = 1'b0;
            #1;
            if (busy || !scl || sda_oe || fifo_rd_en || done) act++;
        end
        chk(tag, act, 0);
    endtask

    initial begin
        vec_t sv;
        int   dn;

        vt[0] = '{16'h0123, 1,  8'hA5, 8'h00, 1,  -1, 609,  1,  0, 4};
        vt[1] = '{16'h0040, 3,  8'h11, 8'h11, 3,  -1, 897,  3,  0, 6};
        vt[2] = '{16'h1234, 1,  8'h5A, 8'h00, 1,  0,  177,  0,  1, 1};
        vt[3] = '{16'hBEEF, 3,  8'hC3, 8'h79, 3,  4,  753,  2,  1, 5};
        vt[4] = '{16'h7FE0, 32, 8'h00, 8'h01, 32, -1, 5073, 32, 0, 35};

        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1;
        chk("reset scl", int'(scl), 1);
        chk("reset sda_oe", int'(sda_oe), 0);
        chk("reset fifo_rd_en", int'(fifo_rd_en), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset ack_err", int'(ack_err), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        #1;

        for (int i = 0; i < 5; i++) run(vt[i], $sformatf("vec%0d", i));

        extra_start_k = 100;
        run(vt[0], "start-while-busy");
        extra_start_k = -1;

        sv      = '{16'h0200, 2, 8'h5C, 8'h11, 1, -1, 1109, 2, 0, 5};
        push_k  = 948;
        hold_lo = 593;
        hold_hi = 947;
        run(sv, "stall");
        chk("stall second pop cycle", pop_at[1], 948);
        push_k  = -1;
        hold_lo = 0;
        hold_hi = -1;

        flush   = 1'b1;
        mon_clr = 1'b1;
        @(negedge sys_clk);
        #1;
        flush   = 1'b0;
        mon_clr = 1'b0;
        fmem[wr_ptr[5:0]] = 8'h77;
        wr_ptr++;
        word_addr = 16'h0A0B;
        byte_cnt  = 6'd1;
        start     = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge sys_clk);
            start = 1'b0;
        end
        #1;
        chk("pre-reset busy", int'(busy), 1);
        sys_rst_n = 1'b0;
        #1;
        chk("mid-reset scl", int'(scl), 1);
        chk("mid-reset sda_oe", int'(sda_oe), 0);
        chk("mid-reset busy", int'(busy), 0);
        dn = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            #1;
            if (done) dn++;
        end
        chk("mid-reset done pulses", dn, 0);
        sys_rst_n = 1'b1;
        chk("mid-reset fifo untouched", wr_ptr - rd_ptr, 1);
        @(negedge sys_clk);
        #1;
        run(vt[0], "post-reset");

        bad_start(0, "ignored start byte_cnt=0");
        bad_start(33, "ignored start byte_cnt=33");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iic_page_writer.md
# iic_page_writer

I2C master write engine for the EEPROM path. It drains the byte FIFO (first-word-fall-through, 8-bit) and sends up to one page of bytes to a 24Cxx-class EEPROM as a single I2C page write: START, device address + W, 16-bit word address, N data bytes, STOP. It sits between the FIFO read port and the open-drain SCL/SDA pads, and it is the only master on the bus.

## Interface
- SYS_CLK_FREQ, 50_000_000, system clock frequency in Hz
- SCL_FREQ, 250_000, SCL frequency in Hz; QCNT = SYS_CLK_FREQ/(SCL_FREQ*4) clocks per quarter-bit (default 50, must be ≥2)
- PAGE_SIZE, 32, maximum bytes per transaction
- DEV_ADDR, 7'b1010000, 7-bit I2C device address
- sys_clk  in  1  system clock; the block uses a single clock domain
- sys_rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- word_addr  in  16  EEPROM word address; latched on an accepted start
- byte_cnt  in  6  number of data bytes, 1..PAGE_SIZE; latched on an accepted start
- fifo_dout  in  8  FIFO head byte, valid when fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  one-cycle pop of the FIFO head
- scl  out  1  SCL, push-pull (single master)
- sda_oe  out  1  1 = pull SDA low, 0 = release SDA
- sda_in  in  1  SDA pad input
- busy  out  1  high from an accepted start until done
- done  out  1  one-cycle pulse at the end of each transaction
- ack_err  out  1  set when a NACK is seen; cleared on the next accepted start

## Operation
- Reset values: scl=1, sda_oe=0, fifo_rd_en=0, busy=0, done=0, ack_err=0, state IDLE, all counters 0.
- Start acceptance: a start is accepted only in IDLE with 1 ≤ byte_cnt ≤ PAGE_SIZE. Any other start is ignored, and no done pulse is produced.
- On an accepted start: latch word_addr and byte_cnt, clear ack_err, and set busy on the next cycle.
- FSM states: IDLE → START → DEV → ACK → ADDR_H → ACK → ADDR_L → ACK → DATA → ACK → (DATA again if bytes remain, else STOP) → DONE → IDLE.
- Bit slot: each bit takes 4 quarters of QCNT clocks.
  - q0: scl=0, SDA is updated.
  - q1 and q2: scl=1.
  - q3: scl=0.
- Bytes are sent MSB first. In the 9th (ACK) slot SDA is released, and sda_in is sampled on the first clock of q2. A sampled value of 0 is ACK.
- START condition (4 quarters), scl=1 throughout: q0–q1 SDA released, q2–q3 SDA low.
- STOP condition (4 quarters): q0 scl=0 with SDA low, q1–q2 scl=1 with SDA low, q3 scl=1 with SDA released.
- Device byte is {DEV_ADDR, 1'b0}, followed by word_addr[15:8], then word_addr[7:0].
- Data load:
  - At the end of each ACK slot that is followed by DATA, the shift register loads fifo_dout.
  - fifo_rd_en pulses high on that same clock, exactly once per data byte.
- FIFO empty at load time: the block holds in q0 of the first data bit with scl=0 and SDA unchanged, and the quarter counter is frozen. The load and pop happen on the first clock with fifo_empty=0.
- NACK on any byte:
  - Set ack_err.
  - Skip the remaining bytes; no further pops.
  - Go to STOP, then DONE. done still pulses.
- Page wrap inside the EEPROM, when word_addr[low] + byte_cnt crosses a page, is the caller's responsibility. The block never splits a transaction.
- Reset mid-transaction: all outputs return to their reset values immediately (the bus is released), and no done pulse is produced.

## Timing
- Accepted start at cycle T: busy=1 at T+1, and the START q0 begins at T+1.
- Transaction length with no stalls: QCNT × (8 + 36×(3+N)) clocks from T+1 to the end of STOP q3. Default QCNT=50 with N=1: 7600 clocks.
- done=1 on the cycle after STOP q3 ends. busy falls on that same cycle.
- A new start is accepted on the cycle after done.
- Pops: the first pop occurs at the end of the ADDR_L ACK slot. Pop k occurs 36×QCNT clocks after pop k−1, plus any stall time.
- ack_err changes only at ACK sample points and on an accepted start.

## Test plan
- N=1, QCNT=4, word_addr=16'h0123, FIFO holds 8'hA5, slave always ACKs:
  - SDA bit sequence is A0, 01, 23, A5, with START and STOP framing.
  - One pop; done after 4×(8+144)=608 clocks; ack_err=0.
- N=3, FIFO holds 11, 22, 33:
  - Bytes sent in that order; exactly 3 fifo_rd_en pulses, each one cycle and spaced 144 clocks apart.
  - busy high throughout the transaction.
- Slave NACKs the device byte:
  - ack_err=1, zero pops, STOP issued, done pulses.
  - FIFO contents untouched.
- N=2, FIFO holds 1 byte, second byte pushed 500 clocks after the first pop:
  - scl held 0 during the wait.
  - Second pop on the first cycle after fifo_empty falls; correct bytes sent.
- sys_rst_n pulled low during ADDR_H:
  - scl=1, sda_oe=0, busy=0 immediately; no done pulse.
  - A later start runs normally.
- Starts that must be ignored:
  - start while busy: ignored.
  - start with byte_cnt=0 or byte_cnt=33: ignored; busy stays 0 and no bus activity occurs.
